keypad_scanner: RTL

- Scans a 4x4 active-low matrix keypad, debounces it and decodes it into the front-panel signals consumed by the microwave top level: the 10-bit one-hot keypad vector and the active-low startn/stopn/clearn levels.
- Sits directly upstream of the microwave top and drives its keypad, startn, stopn and clearn inputs.
- door_closed is not handled here.
- Only one key is recognised at a time.

---
 rtl/keypad_scanner.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module   : keypad_scanner
// Brief    : 4x4 active-low matrix keypad scanner with debounce and decode
//            into the microwave front-panel levels (one-hot digit vector,
//            active-low start/stop/clear) plus a press strobe and key code.
// Revision : 1.0 - initial release
// ============================================================================
module keypad_scanner #(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_TICKS = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] row_in,
    output logic [3:0] col_drive,
    output logic [9:0] keypad,
    output logic       startn,
    output logic       stopn,
    output logic       clearn,
    output logic       key_strobe,
    output logic [3:0] key_code
);

    localparam int c_tick_w = $clog2(SCAN_DIV);
    localparam int c_cnt_w  = $clog2(DEBOUNCE_TICKS + 1);

    localparam logic [c_tick_w-1:0] c_tick_last = c_tick_w'(SCAN_DIV - 1);
    localparam logic [c_cnt_w-1:0]  c_deb_max   = c_cnt_w'(DEBOUNCE_TICKS);

    localparam logic [1:0] c_st_scan     = 2'd0;
    localparam logic [1:0] c_st_debounce = 2'd1;
    localparam logic [1:0] c_st_held     = 2'd2;

    logic [3:0]          r_rs_meta;
    logic [3:0]          r_rs;
    logic [c_tick_w-1:0] r_tick_cnt;
    logic                w_tick;
    logic [1:0]          r_state;
    logic [3:0]          r_cand;       // {row, col} of the key being tracked
    logic [3:0]          r_cand_pat;   // row pattern seen when it was detected
    logic [c_cnt_w-1:0]  r_deb_cnt;
    logic [c_cnt_w-1:0]  r_rel_cnt;
    logic [c_cnt_w-1:0]  w_deb_inc;
    logic                w_single_low;
    logic [1:0]          w_row_idx;
    logic [1:0]          w_col_idx;
    logic [3:0]          w_col_next;
    logic [9:0]          w_dec_keypad;
    logic                w_dec_start;
    logic                w_dec_stop;
    logic                w_dec_clear;

    // Two-flop synchroniser; idle rows are pulled up so reset to all-ones
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rs_meta <= 4'b1111;
            r_rs      <= 4'b1111;
        end else begin
            r_rs_meta <= row_in;
            r_rs      <= r_rs_meta;
        end
    end

    // Free-running scan tick divider, runs regardless of FSM state
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_tick_cnt <= '0;
        end else if (r_tick_cnt == c_tick_last) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
        end
    end

    assign w_tick     = (r_tick_cnt == c_tick_last);
    assign w_col_next = {col_drive[2:0], col_drive[3]};
    assign w_deb_inc  = (r_deb_cnt == c_deb_max) ? r_deb_cnt : r_deb_cnt + 1'b1;

    // Classify the synchronised rows: exactly one low means a usable press
    always_comb begin
        w_single_low = 1'b1;
        w_row_idx    = 2'd0;
        case (r_rs)
            4'b1110: w_row_idx = 2'd0;
            4'b1101: w_row_idx = 2'd1;
            4'b1011: w_row_idx = 2'd2;
            4'b0111: w_row_idx = 2'd3;
            default: w_single_low = 1'b0;
        endcase
    end

    // Index of the column currently driven low
    always_comb begin
        w_col_idx = 2'd0;
        case (col_drive)
            4'b1101: w_col_idx = 2'd1;
            4'b1011: w_col_idx = 2'd2;
            4'b0111: w_col_idx = 2'd3;
            default: w_col_idx = 2'd0;
        endcase
    end

    // Decode the candidate key into front-panel functions; *, # and D map to nothing
    always_comb begin
        w_dec_keypad = '0;
        w_dec_start  = 1'b0;
        w_dec_stop   = 1'b0;
        w_dec_clear  = 1'b0;
        case (r_cand)
            4'd0:    w_dec_keypad[1] = 1'b1;
            4'd1:    w_dec_keypad[2] = 1'b1;
            4'd2:    w_dec_keypad[3] = 1'b1;
            4'd3:    w_dec_start     = 1'b1;
            4'd4:    w_dec_keypad[4] = 1'b1;
            4'd5:    w_dec_keypad[5] = 1'b1;
            4'd6:    w_dec_keypad[6] = 1'b1;
            4'd7:    w_dec_stop      = 1'b1;
            4'd8:    w_dec_keypad[7] = 1'b1;
            4'd9:    w_dec_keypad[8] = 1'b1;
            4'd10:   w_dec_keypad[9] = 1'b1;
            4'd11:   w_dec_clear     = 1'b1;
            4'd13:   w_dec_keypad[0] = 1'b1;
            default: ;
        endcase
    end

    // Scan / debounce / held state machine and registered outputs, stepped on ticks
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= c_st_scan;
            col_drive  <= 4'b1110;
            r_cand     <= '0;
            r_cand_pat <= 4'b1111;
            r_deb_cnt  <= '0;
            r_rel_cnt  <= '0;
            keypad     <= '0;
            startn     <= 1'b1;
            stopn      <= 1'b1;
            clearn     <= 1'b1;
            key_strobe <= 1'b0;
            key_code   <= '0;
        end else begin
            key_strobe <= 1'b0;
            if (w_tick) begin
                case (r_state)
                    c_st_scan: begin
                        if (w_single_low) begin
                            // Freeze the column and start qualifying this key
                            r_cand     <= {w_row_idx, w_col_idx};
                            r_cand_pat <= r_rs;
                            r_deb_cnt  <= '0;
                            r_state    <= c_st_debounce;
                        end else begin
                            // Idle or ghosted multi-key pattern: keep scanning
                            col_drive <= w_col_next;
                        end
                    end
                    c_st_debounce: begin
                        if (r_rs == r_cand_pat) begin
                            if (w_deb_inc == c_deb_max) begin
                                r_state    <= c_st_held;
                                r_deb_cnt  <= '0;
                                r_rel_cnt  <= '0;
                                key_strobe <= 1'b1;
                                key_code   <= r_cand;
                                keypad     <= w_dec_keypad;
                                startn     <= ~w_dec_start;
                                stopn      <= ~w_dec_stop;
                                clearn     <= ~w_dec_clear;
                            end else begin
                                r_deb_cnt <= w_deb_inc;
                            end
                        end else begin
                            r_state   <= c_st_scan;
                            r_deb_cnt <= '0;
                            col_drive <= w_col_next;
                        end
                    end
                    c_st_held: begin
                        if (r_rs == 4'b1111) begin
                            // Release is taken on the tick after the count is full
                            if (r_rel_cnt == c_deb_max) begin
                                r_state   <= c_st_scan;
                                r_rel_cnt <= '0;
                                col_drive <= w_col_next;
                                keypad    <= '0;
                                startn    <= 1'b1;
                                stopn     <= 1'b1;
                                clearn    <= 1'b1;
                            end else begin
                                r_rel_cnt <= r_rel_cnt + 1'b1;
                            end
                        end else if (!r_rs[r_cand[3:2]]) begin
                            r_rel_cnt <= '0;
                        end
                    end
                    default: begin
                        r_state <= c_st_scan;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire
